// File: rtl/sss_demod_if.sv
// Stream bundle for sss_demod: SSB grid input, N_id_2 side channel, hard-bit output.
interface sss_demod_if #(
  parameter int IN_DW = 32
);
  logic [IN_DW-1:0] s_axis_in_tdata;
  logic             s_axis_in_tvalid;
  logic             s_axis_in_tuser;
  logic [1:0]       N_id_2_i;
  logic             N_id_2_valid_i;
  logic             m_axis_out_tdata;
  logic             m_axis_out_tvalid;
  logic             sss_done_o;

  // Demodulator side
  modport slave (
    input  s_axis_in_tdata, s_axis_in_tvalid, s_axis_in_tuser,
    input  N_id_2_i, N_id_2_valid_i,
    output m_axis_out_tdata, m_axis_out_tvalid, sss_done_o
  );

  // Source/sink side (FFT extractor, PSS detector, SSS detector)
  modport master (
    output s_axis_in_tdata, s_axis_in_tvalid, s_axis_in_tuser,
    output N_id_2_i, N_id_2_valid_i,
    input  m_axis_out_tdata, m_axis_out_tvalid, sss_done_o
  );
endinterface

// File: rtl/sss_demod.sv
// Coherent BPSK demodulator: channel estimate from the PSS symbol, SSS
// subcarriers equalised against it, 127 hard bits per SSB.
module sss_demod #(
  parameter int IN_DW = 32
) (
  input  logic       clk_i,
  input  logic       reset_i,
  sss_demod_if.slave bus
);
  localparam int W  = IN_DW / 2;
  localparam int PW = 2 * W;

  // PSS m-sequence x(i): x(i+7) = x(i+4) ^ x(i), x[6:0] = 1110110
  function automatic logic [126:0] gen_pss_x();
    logic [126:0] x;
    x = '0;
    x[6:0] = 7'b1110110;
    for (int i = 0; i < 120; i++) x[i+7] = x[i+4] ^ x[i];
    return x;
  endfunction

  localparam logic [126:0] PSS_X = gen_pss_x();

  // Negation that maps the most negative code to the most positive one
  function automatic logic signed [W-1:0] neg_sat(input logic signed [W-1:0] a);
    if (a == {1'b1, {(W-1){1'b0}}}) return {1'b0, {(W-1){1'b1}}};
    return -a;
  endfunction

  // Hard decision: 1 for a non-negative correlation
  function automatic logic hard_bit(input logic signed [PW:0] r);
    return ~r[PW];
  endfunction

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT_SSB,
    ST_PSS,
    ST_SKIP,
    ST_SSS
  } state_t;

  state_t r_state, w_state_nxt;
  logic [7:0] r_k, w_k_nxt;
  logic [6:0] r_ptr, w_ptr_nxt;
  logic [1:0] r_nid2;
  logic [6:0] w_ptr_start;

  logic signed [W-1:0]     w_rx_re, w_rx_im;
  logic                    w_in_band;
  logic [6:0]              w_n, w_rd_addr;
  logic                    w_pss_wr, w_sss_rd;
  logic [IN_DW-1:0]        w_h_wr, w_h_rd;
  logic signed [W-1:0]     w_h_re, w_h_im;
  logic signed [PW-1:0]    w_prod_re, w_prod_im;
  logic signed [PW:0]      w_sum;

  logic [IN_DW-1:0]        r_hbuf [0:126];

  logic signed [PW-1:0]    r_prod_re_p1, r_prod_im_p1;
  logic                    r_vld_p1, r_done_p1;
  logic                    r_bit_p2, r_vld_p2, r_done_p2;

  assign w_rx_re   = bus.s_axis_in_tdata[W-1:0];
  assign w_rx_im   = bus.s_axis_in_tdata[IN_DW-1:W];
  assign w_in_band = (r_k >= 8'd56) && (r_k <= 8'd182);
  assign w_n       = 7'(r_k - 8'd56);
  assign w_rd_addr = w_in_band ? w_n : 7'd0;

  assign w_pss_wr = bus.s_axis_in_tvalid && !bus.s_axis_in_tuser &&
                    (r_state == ST_PSS) && w_in_band;
  assign w_sss_rd = bus.s_axis_in_tvalid && !bus.s_axis_in_tuser &&
                    (r_state == ST_SSS) && w_in_band;

  always_comb begin
    case (r_nid2)
      2'd1:    w_ptr_start = 7'd43;
      2'd2:    w_ptr_start = 7'd86;
      default: w_ptr_start = 7'd0;
    endcase
  end

  // h = rx * d_PSS(n); d = -1 where the PSS sequence bit is 1
  assign w_h_wr = PSS_X[r_ptr] ? {neg_sat(w_rx_im), neg_sat(w_rx_re)}
                               : {w_rx_im, w_rx_re};

  assign w_h_rd = r_hbuf[w_rd_addr];
  assign w_h_re = w_h_rd[W-1:0];
  assign w_h_im = w_h_rd[IN_DW-1:W];

  // Re(y * conj(h)) partial products
  assign w_prod_re = PW'(w_rx_re) * PW'(w_h_re);
  assign w_prod_im = PW'(w_rx_im) * PW'(w_h_im);

  // Next-state logic: symbol sequencing, subcarrier counter and PSS pointer
  always_comb begin
    w_state_nxt = r_state;
    w_k_nxt     = r_k;
    w_ptr_nxt   = r_ptr;
    case (r_state)
      ST_IDLE: begin
        if (bus.N_id_2_valid_i) w_state_nxt = ST_WAIT_SSB;
      end
      ST_WAIT_SSB: begin
        if (bus.s_axis_in_tvalid && bus.s_axis_in_tuser) begin
          w_state_nxt = ST_PSS;
          w_k_nxt     = 8'd1;
          w_ptr_nxt   = w_ptr_start;
        end
      end
      ST_PSS, ST_SKIP, ST_SSS: begin
        if (bus.s_axis_in_tvalid) begin
          if (bus.s_axis_in_tuser) begin
            // tuser sample is itself k = 0 of a fresh PSS symbol
            w_state_nxt = ST_PSS;
            w_k_nxt     = 8'd1;
            w_ptr_nxt   = w_ptr_start;
          end else begin
            if (r_k == 8'd239) begin
              w_k_nxt = 8'd0;
              case (r_state)
                ST_PSS:  w_state_nxt = ST_SKIP;
                ST_SKIP: w_state_nxt = ST_SSS;
                default: w_state_nxt = ST_WAIT_SSB;
              endcase
            end else begin
              w_k_nxt = r_k + 8'd1;
            end
            if (w_pss_wr) w_ptr_nxt = (r_ptr == 7'd126) ? 7'd0 : r_ptr + 7'd1;
          end
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // State register, counters and latched N_id_2
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_state <= ST_IDLE;
      r_k     <= '0;
      r_ptr   <= '0;
      r_nid2  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_k     <= w_k_nxt;
      r_ptr   <= w_ptr_nxt;
      if (bus.N_id_2_valid_i) r_nid2 <= bus.N_id_2_i;
    end
  end

  // Channel estimate buffer, written during the PSS symbol only
  always_ff @(posedge clk_i) begin
    if (w_pss_wr) r_hbuf[w_n] <= w_h_wr;
  end

  // ---- stage p1: registered products ----
  // Control valid/done for stage p1
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_vld_p1  <= 1'b0;
      r_done_p1 <= 1'b0;
    end else begin
      r_vld_p1  <= w_sss_rd;
      r_done_p1 <= w_sss_rd && (r_k == 8'd182);
    end
  end

  // Product data for stage p1
  always_ff @(posedge clk_i) begin
    r_prod_re_p1 <= w_prod_re;
    r_prod_im_p1 <= w_prod_im;
  end

  // ---- stage p2: registered sign of the sum ----
  assign w_sum = $signed({r_prod_re_p1[PW-1], r_prod_re_p1}) +
                 $signed({r_prod_im_p1[PW-1], r_prod_im_p1});

  // Output bit, valid and done for stage p2
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_bit_p2  <= 1'b0;
      r_vld_p2  <= 1'b0;
      r_done_p2 <= 1'b0;
    end else begin
      r_vld_p2  <= r_vld_p1;
      r_done_p2 <= r_done_p1;
      if (r_vld_p1) r_bit_p2 <= hard_bit(w_sum);
    end
  end

  assign bus.m_axis_out_tdata  = r_bit_p2;
  assign bus.m_axis_out_tvalid = r_vld_p2;
  assign bus.sss_done_o        = r_done_p2;
endmodule
